digit_scan_counter: RTL

Parametrised digit-scan sequencer for the multiplexed 7-segment display path. Divides the system clock into per-digit time slots, cycles a digit index over a run-time selectable number of active digits (8/16/32-bit display modes), and drives registered active-low anode enables with a blanking guard at each slot start to suppress ghosting. Successor to the fixed-modulus display counter: adds reset, enable, prescaling, run-time digit count, one-hot anode generation, and tick/frame strobes.

---
 rtl/scan_pkg.sv | 31 +++
 rtl/digit_scan_counter_tick_gen.sv | 55 +++++
 rtl/digit_scan_counter.sv | 85 ++++++++
 3 files changed

// File: rtl/scan_pkg.sv
// +--------------------------------------------------------------------+
// | scan_pkg : shared constants and helpers for the digit scan path.    |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

package scan_pkg;

   localparam int MODE8  = 2;
   localparam int MODE16 = 4;
   localparam int MODE32 = 8;

   // Zero digits would stall the scan on nothing, so it is promoted to one.
   function automatic int unsigned clamp_digits(input int unsigned req,
                                                input int unsigned n_max);
      if (req == 0)
         return 1;
      else if (req > n_max)
         return n_max;
      else
         return req;
   endfunction

   function automatic logic anode_n_bit(input int unsigned idx,
                                        input int unsigned pos);
      return (idx == pos) ? 1'b0 : 1'b1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/digit_scan_counter_tick_gen.sv
// +--------------------------------------------------------------------+
// | tick_gen : per-slot prescaler with wrap strobe and blanking flag.   |
// | Revision : 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
`default_nettype none

module tick_gen #(
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic clk_out,
   input  logic reset,
   input  logic enable,
   output logic pre_wrap,
   output logic in_blank
);

   localparam int c_PRE_W = $clog2(PRESCALE);

   logic [c_PRE_W-1:0] r_pre;
   logic [c_PRE_W-1:0] w_pre_next;
   logic               w_at_end;

   always_comb begin
      w_at_end = (r_pre == c_PRE_W'(PRESCALE - 1));
      pre_wrap = enable && w_at_end;
      if (reset)
         w_pre_next = '0;
      else if (!enable)
         w_pre_next = r_pre;
      else if (w_at_end)
         w_pre_next = '0;
      else
         w_pre_next = r_pre + c_PRE_W'(1);
   end

   always_ff @(posedge clk_out) begin
      if (reset)
         r_pre <= '0;
      else
         r_pre <= w_pre_next;
   end

   // Blanking looks at the next prescaler value so the registered anodes line up with it.
   generate
      if (BLANK_CYCLES > 0) begin : g_blank_on
         assign in_blank = (w_pre_next < c_PRE_W'(BLANK_CYCLES));
      end else begin : g_blank_off
         assign in_blank = 1'b0;
      end
   endgenerate

endmodule

`default_nettype wire

// File: rtl/digit_scan_counter.sv
// +--------------------------------------------------------------------+
// | digit_scan_counter : multiplexed 7-seg digit scanner, active-low    |
// | anodes with slot blanking.   Revision : 1.0 - initial release       |
// +--------------------------------------------------------------------+
`default_nettype none

module digit_scan_counter #(
   parameter int N_DIGITS     = 8,
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 4
) (
   input  logic                          clk_out,
   input  logic                          reset,
   input  logic                          enable,
   input  logic [$clog2(N_DIGITS+1)-1:0] digits_active,
   output logic [$clog2(N_DIGITS)-1:0]   digit_idx,
   output logic [N_DIGITS-1:0]           anode_n,
   output logic                          slot_tick,
   output logic                          frame_done
);

   import scan_pkg::*;

   localparam int c_IDX_W = $clog2(N_DIGITS);
   localparam int c_CNT_W = $clog2(N_DIGITS + 1);

   logic                w_pre_wrap;
   logic                w_in_blank;
   logic [c_CNT_W-1:0]  w_n_eff;
   logic [c_CNT_W-1:0]  w_idx_inc;
   logic [c_IDX_W-1:0]  w_idx_next;
   logic [N_DIGITS-1:0] w_anode_lit;
   logic [N_DIGITS-1:0] w_anode_next;

   logic [c_IDX_W-1:0]  r_idx;
   logic [N_DIGITS-1:0] r_anode_n;
   logic                r_slot_tick;
   logic                r_frame_done;

   tick_gen #(
      .PRESCALE     (PRESCALE),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_tick_gen (
      .clk_out  (clk_out),
      .reset    (reset),
      .enable   (enable),
      .pre_wrap (w_pre_wrap),
      .in_blank (w_in_blank)
   );

   assign w_n_eff = c_CNT_W'(clamp_digits(32'(digits_active), N_DIGITS));

   // An index already past a shrunk digit count simply wraps at the next boundary.
   always_comb begin
      w_idx_inc  = c_CNT_W'(r_idx) + c_CNT_W'(1);
      w_idx_next = r_idx;
      if (w_pre_wrap)
         w_idx_next = (w_idx_inc >= w_n_eff) ? '0 : c_IDX_W'(w_idx_inc);
      for (int b = 0; b < N_DIGITS; b++)
         w_anode_lit[b] = anode_n_bit(32'(w_idx_next), b);
      w_anode_next = (!enable || w_in_blank) ? '1 : w_anode_lit;
   end

   always_ff @(posedge clk_out) begin
      if (reset) begin
         r_idx        <= '0;
         r_anode_n    <= '1;
         r_slot_tick  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_idx        <= w_idx_next;
         r_anode_n    <= w_anode_next;
         r_slot_tick  <= w_pre_wrap;
         r_frame_done <= w_pre_wrap && (w_idx_next == '0);
      end
   end

   assign digit_idx  = r_idx;
   assign anode_n    = r_anode_n;
   assign slot_tick  = r_slot_tick;
   assign frame_done = r_frame_done;

endmodule

`default_nettype wire
